// File: rtl/mul_div_unit.sv
// Multiply/divide unit: single-cycle registered multiply, 32-step restoring divide with sign fix.
// Define MDU_DIV0_FAST_EN to complete divide-by-zero directly from IDLE/DONE in one cycle.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpDiv   = 2'b10;

`ifdef MDU_DIV0_FAST_EN
    localparam bit Div0Fast = 1'b1;
`else
    localparam bit Div0Fast = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        accept;
    logic        sign_a, sign_b, mul_signed;
    logic [31:0] mag_b;
    logic [63:0] a_ext, b_ext, prod;
    logic [32:0] shifted, diff;

    always_comb begin
        mul_signed = (op_q == OpMult);
        sign_a     = (op_q == OpDiv) && a_q[31];
        sign_b     = (op_q == OpDiv) && b_q[31];
        mag_b      = sign_b ? -b_q : b_q;
        a_ext      = {{32{mul_signed & a_q[31]}}, a_q};
        b_ext      = {{32{mul_signed & b_q[31]}}, b_q};
        prod       = a_ext * b_ext;
        // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
        shifted    = {rem_q, quo_q[31]};
        diff       = shifted - {1'b0, mag_b};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        accept = start && !flush && (state_q == StIdle || state_q == StDone);
        stall  = accept || state_q == StMul || state_q == StDiv || state_q == StFix;
        done   = (state_q == StDone);

        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (start) begin
                        op_d = op;
                        a_d  = a;
                        b_d  = b;
                        if (!op[1]) begin
                            state_d = StMul;
                        end else if (Div0Fast && b == '0) begin
                            state_d = StDone;
                            hi_d    = a;
                            lo_d    = '1;
                        end else begin
                            state_d = StDiv;
                            cnt_d   = 5'd31;
                            rem_d   = '0;
                            quo_d   = (op == OpDiv && a[31]) ? -a : a;
                        end
                    end
                end
                StMul: begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = StDone;
                end
                StDiv: begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                StFix: begin
                    if (b_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        lo_d = (sign_a ^ sign_b) ? -quo_q : quo_q;
                        hi_d = sign_a ? -rem_q : rem_q;
                    end
                    state_d = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand sequences, random vs. model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
        if (!o[1]) return 2;
`ifdef MDU_DIV0_FAST_EN
        if (y == 32'd0) return 1;
`endif
        return 34;
    endfunction

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy;
        int     qi, ri;
        case (o)
            2'b00: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            2'b01: return {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                qi = $signed(x) / $signed(y);
                ri = $signed(x) % $signed(y);
                return {32'(ri), 32'(qi)};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one op, scramble inputs while busy, and check latency, stall profile and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n, lat;
        bit seen;
        lat = exp_lat(o, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; flush = 1'b0;
        #1;
        check("accept_stall", 64'(stall), 64'd1);
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            start = 1'($urandom_range(1, 0));
            op = 2'($urandom_range(3, 0));
            a = $urandom;
            b = $urandom;
            #1;
            if (done) begin
                seen = 1;
                start = 1'b0;
                #1;
            end else if (stall !== 1'b1) begin
                check("busy_stall", 64'(stall), 64'd1);
            end
        end
        check("latency", 64'(n), 64'(lat));
        if (seen) begin
            check("done_stall", 64'(stall), 64'd0);
            check("hi", 64'(hi), 64'(ehi));
            check("lo", 64'(lo), 64'(elo));
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic step(input logic s);
        @(negedge clk);
        start = s;
        #1;
    endtask

    vec_t        vecs[6];
    logic [63:0] e;
    logic [31:0] ra, rb, save_hi, save_lo;
    logic [1:0]  rop;

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;

        // Reset state, and start accepted in first cycle with rst low
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        #1;
        check("first_accept_stall", 64'(stall), 64'd1);
        step(1'b0);
        check("first_busy", 64'(done), 64'd0);
        step(1'b0);
        check("first_done", 64'(done), 64'd1);
        check("first_lo", 64'(lo), 64'd12);

        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{2'b10, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end
        run_op(2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // Back-to-back: new start accepted in the DONE cycle
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        #1;
        step(1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'd2;
        #1;
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_stall", 64'(stall), 64'd1);
        check("b2b_lo1", 64'(lo), 64'd42);
        step(1'b0);
        check("b2b_busy", {63'd0, done}, 64'd0);
        step(1'b0);
        check("b2b_done2", 64'(done), 64'd1);
        check("b2b_res2", {hi, lo}, 64'h00000001_FFFFFFFE);
        step(1'b0);

        // Flush mid-divide, then a multiply accepted the cycle after
        save_hi = hi;
        save_lo = lo;
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        #1;
        for (int i = 1; i <= 9; i++) step(1'b0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hilo", {hi, lo}, {save_hi, save_lo});
        start = 1'b1; op = 2'b00; a = 32'hFFFFFFFD; b = 32'd7;
        #1;
        check("post_flush_accept", 64'(stall), 64'd1);
        step(1'b0);
        check("post_flush_busy", 64'(done), 64'd0);
        step(1'b0);
        check("post_flush_done", 64'(done), 64'd1);
        check("post_flush_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        step(1'b0);

        // Flush wins over start in the same cycle
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3;
        #1;
        check("flush_start_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_start_idle", 64'(stall), 64'd0);
        for (int i = 0; i < 36; i++) begin
            step(1'b0);
            if (done) check("flush_start_no_done", 64'(done), 64'd0);
        end

        // Reset aborts an in-flight divide with no done and clears results
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd3;
        #1;
        for (int i = 0; i < 4; i++) step(1'b0);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; flush = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; flush = 1'b0;
        #1;
        check("rst_abort_stall", 64'(stall), 64'd0);
        check("rst_abort_done", 64'(done), 64'd0);
        check("rst_abort_hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < 36; i++) begin
            step(1'b0);
            if (done) check("rst_abort_no_done", 64'(done), 64'd0);
        end

        // Random ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(3, 0));
            ra = $urandom;
            case ($urandom_range(7, 0))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(15, 1);
                3:       rb = -$urandom_range(15, 1);
                default: rb = $urandom;
            endcase
            if ($urandom_range(3, 0) == 0) ra = ra >> $urandom_range(31, 0);
            e = model(rop, ra, rb);
            run_op(rop, ra, rb, e[63:32], e[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
